// File: rtl/hpram_pkg.sv
// Shared types and constants for the HyperRAM two-port arbiter.
package hpram_pkg;

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        IDLE      = 3'd1,
        WRITE     = 3'd2,
        READ      = 3'd3,
        GAP       = 3'd4
    } state_e;

    localparam logic CMD_WR = 1'b1;
    localparam logic CMD_RD = 1'b0;

    localparam int BURST_BEATS_DEF = 4;

endpackage

// File: rtl/hpram_rr_pick.sv
// Two-way round-robin picker: combinational pick plus the last-served pointer.
module hpram_rr_pick (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       pick
);

    logic last_q;
    logic last_d;

    always_comb begin
        // On a tie the port not served last wins; otherwise the lone requester.
        if (req == 2'b11) begin
            pick = ~last_q;
        end else begin
            pick = req[1] & ~req[0];
        end
        last_d = advance ? pick : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/hpram_arbiter.sv
// Round-robin arbiter serialising fixed-length bursts from two requesters
// onto the HyperRAM user port, with write-beat sequencing and read steering.
module hpram_arbiter
    import hpram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 22,
    parameter int DQ_WIDTH    = 8,
    parameter int MASK_WIDTH  = 4,
    parameter int BURST_BEATS = BURST_BEATS_DEF,
    parameter int CMD_GAP     = 8,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init_calib,
    input  logic [1:0]              req,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [8*DQ_WIDTH-1:0]   wdata,
    input  logic [2*MASK_WIDTH-1:0] wmask,
    output logic [1:0]              gnt,
    output logic [1:0]              wd_adv,
    output logic [4*DQ_WIDTH-1:0]   rdata,
    output logic [1:0]              rvalid,
    output logic                    busy,
    output logic                    error,
    output logic                    cmd,
    output logic                    cmd_en,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic [4*DQ_WIDTH-1:0]   wr_data,
    output logic [MASK_WIDTH-1:0]   data_mask,
    input  logic [4*DQ_WIDTH-1:0]   rd_data,
    input  logic                    rd_data_valid,
    output state_e                  state_dbg
);

    localparam int DW = 4 * DQ_WIDTH;
    localparam int BW = $clog2(BURST_BEATS + 1);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS - 1);

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [7:0]              gap_q, gap_d;
    logic [TW-1:0]           to_q, to_d;
    logic [1:0]              gnt_q, gnt_d;
    logic                    cmd_en_q, cmd_en_d;
    logic                    cmd_q, cmd_d;
    logic [1:0]              rvalid_q, rvalid_d;
    logic [DW-1:0]           rdata_q, rdata_d;
    logic                    error_q, error_d;
    logic                    busy_q, busy_d;

    logic       pick;
    logic       grant;
    logic [1:0] owner_mask;
    logic       gap_last;
    logic       read_done;

    hpram_rr_pick u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (grant),
        .pick    (pick)
    );

    assign owner_mask = owner_q ? 2'b10 : 2'b01;
    assign gap_last   = (CMD_GAP == 0) || (gap_q >= 8'(CMD_GAP - 1));
    assign read_done  = rd_data_valid && (beat_q == LAST_BEAT);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        to_d     = to_q;
        gnt_d    = 2'b00;
        cmd_en_d = 1'b0;
        cmd_d    = cmd_q;
        rvalid_d = 2'b00;
        rdata_d  = rd_data_valid ? rd_data : rdata_q;
        error_d  = error_q;
        grant    = 1'b0;

        case (state_q)
            WAIT_INIT: begin
                if (init_calib) state_d = IDLE;
            end
            IDLE: begin
                if (|req) begin
                    grant    = 1'b1;
                    owner_d  = pick;
                    addr_d   = pick ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                    state_d  = req_we[pick] ? WRITE : READ;
                    cmd_d    = req_we[pick] ? CMD_WR : CMD_RD;
                    gnt_d    = pick ? 2'b10 : 2'b01;
                    cmd_en_d = 1'b1;
                    beat_d   = '0;
                    to_d     = '0;
                end
            end
            WRITE: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = GAP;
                    gap_d   = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            READ: begin
                if (to_q != TW'(RD_TIMEOUT)) to_d = to_q + TW'(1);
                if (rd_data_valid) begin
                    rvalid_d = owner_mask;
                    if (!read_done) beat_d = beat_q + BW'(1);
                end
                // A beat completing the burst takes precedence over a timeout in the same cycle.
                if (read_done) begin
                    state_d = GAP;
                    gap_d   = '0;
                end else if (to_q >= TW'(RD_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = GAP;
                    gap_d   = '0;
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_d = IDLE;
                end else if (gap_q != 8'hFF) begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = WAIT_INIT;
        endcase

        if (rd_data_valid && (state_q != READ)) error_d = 1'b1;

        // Losing calibration aborts everything in flight without a grant or beat.
        if (!init_calib) begin
            state_d  = WAIT_INIT;
            gnt_d    = 2'b00;
            cmd_en_d = 1'b0;
            rvalid_d = 2'b00;
            grant    = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_INIT;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            beat_q   <= '0;
            gap_q    <= '0;
            to_q     <= '0;
            gnt_q    <= 2'b00;
            cmd_en_q <= 1'b0;
            cmd_q    <= 1'b0;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            to_q     <= to_d;
            gnt_q    <= gnt_d;
            cmd_en_q <= cmd_en_d;
            cmd_q    <= cmd_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign cmd_en    = cmd_en_q;
    assign cmd       = cmd_q;
    assign addr      = addr_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign error     = error_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;
    assign wd_adv    = (state_q == WRITE) ? owner_mask : 2'b00;
    assign wr_data   = (state_q != WRITE) ? '0 :
                       owner_q ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    assign data_mask = (state_q != WRITE) ? '0 :
                       owner_q ? wmask[2*MASK_WIDTH-1:MASK_WIDTH] : wmask[MASK_WIDTH-1:0];

endmodule
